// File: rtl/frogg_round_ctrl.sv
// Frogger round/lives sequencer: spawn, play, hit and win phases timed in
// video frames, tracking lives, level, score and per-level car speed.
//
// Ports:
//   i_Clk, i_Rst_n       pixel clock, async active-low reset
//   i_Start              start request (IDLE / GAME_OVER)
//   i_Frame_Tick         one-clock pulse per video frame
//   i_Frog_Home          frog reached the top row
//   i_Collision          frog overlaps a car
//   o_Game_Active        cars and frog movement enabled (PLAY)
//   o_Frog_Reset         one-clock pulse on SPAWN entry
//   o_Game_Over          high in GAME_OVER
//   o_Lives/o_Level/o_Score   game counters
//   o_Car_Speed          clocks per car pixel step for the current level
//   o_State              state encoding for debug/display
module frogg_round_ctrl #(
    parameter int unsigned c_LIVES        = 3,
    parameter int unsigned c_MAX_LEVEL    = 7,
    parameter int unsigned c_BASE_SPEED   = 100000,
    parameter int unsigned c_SPEED_STEP   = 10000,
    parameter int unsigned c_MIN_SPEED    = 20000,
    parameter int unsigned c_SPAWN_FRAMES = 30,
    parameter int unsigned c_HIT_FRAMES   = 60,
    parameter int unsigned c_WIN_FRAMES   = 60
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Start,
    input  logic        i_Frame_Tick,
    input  logic        i_Frog_Home,
    input  logic        i_Collision,
    output logic        o_Game_Active,
    output logic        o_Frog_Reset,
    output logic        o_Game_Over,
    output logic [2:0]  o_Lives,
    output logic [3:0]  o_Level,
    output logic [7:0]  o_Score,
    output logic [23:0] o_Car_Speed,
    output logic [2:0]  o_State
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SPAWN = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_HIT   = 3'd3;
    localparam logic [2:0] S_WIN   = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    localparam logic [2:0]  LP_LIVES = 3'(c_LIVES);
    localparam logic [3:0]  LP_MAXL  = 4'(c_MAX_LEVEL);
    localparam logic [23:0] LP_BASE  = 24'(c_BASE_SPEED);
    localparam logic [23:0] LP_STEP  = 24'(c_SPEED_STEP);
    localparam logic [23:0] LP_MIN   = 24'(c_MIN_SPEED);
    localparam logic [7:0]  LP_SPAWN = 8'(c_SPAWN_FRAMES);
    localparam logic [7:0]  LP_HIT   = 8'(c_HIT_FRAMES);
    localparam logic [7:0]  LP_WIN   = 8'(c_WIN_FRAMES);

    logic [2:0]  r_State;
    logic [2:0]  w_Next_State;
    logic [7:0]  r_Frame_Cnt;
    logic [7:0]  w_Frames;
    logic        w_Timed;
    logic        w_Timer_Done;
    logic [2:0]  r_Lives;
    logic [3:0]  r_Level;
    logic [7:0]  r_Score;
    logic [23:0] r_Car_Speed;
    logic [23:0] w_Speed;
    logic [27:0] w_Dec;
    logic [23:0] w_Diff;
    logic        r_Game_Active;
    logic        r_Frog_Reset;
    logic        r_Game_Over;
    logic        w_Game_Active;
    logic        w_Frog_Reset;
    logic        w_Game_Over;
    logic        w_Load;

    // Frame budget of the current timed state; zero means leave at once.
    always_comb begin
        w_Frames = 8'd0;
        w_Timed  = 1'b0;
        unique case (r_State)
            S_SPAWN: begin w_Frames = LP_SPAWN; w_Timed = 1'b1; end
            S_HIT:   begin w_Frames = LP_HIT;   w_Timed = 1'b1; end
            S_WIN:   begin w_Frames = LP_WIN;   w_Timed = 1'b1; end
            default: begin w_Frames = 8'd0;     w_Timed = 1'b0; end
        endcase
    end

    // Done on the clock that samples the Nth tick (count already N-1).
    assign w_Timer_Done = (w_Frames == 8'd0) ||
                          (i_Frame_Tick && (r_Frame_Cnt == w_Frames - 8'd1));

    assign w_Load = ((r_State == S_IDLE) || (r_State == S_OVER)) && i_Start;

    // State register
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) r_State <= S_IDLE;
        else          r_State <= w_Next_State;
    end

    // Next-state logic
    always_comb begin
        w_Next_State = r_State;
        unique case (r_State)
            S_IDLE, S_OVER: if (i_Start) w_Next_State = S_SPAWN;
            S_SPAWN: if (w_Timer_Done) w_Next_State = S_PLAY;
            S_PLAY: begin
                if (i_Frog_Home)      w_Next_State = S_WIN;
                else if (i_Collision) w_Next_State = S_HIT;
            end
            S_HIT: begin
                if (w_Timer_Done)
                    w_Next_State = (r_Lives == 3'd0) ? S_OVER : S_SPAWN;
            end
            S_WIN: if (w_Timer_Done) w_Next_State = S_SPAWN;
            default: w_Next_State = S_IDLE;
        endcase
    end

    // Output logic, computed from the next state so the registers
    // line up with the state they describe.
    always_comb begin
        w_Game_Active = (w_Next_State == S_PLAY);
        w_Game_Over   = (w_Next_State == S_OVER);
        w_Frog_Reset  = (w_Next_State == S_SPAWN) && (r_State != S_SPAWN);
    end

    // Speed: floor check done before subtracting so it never wraps.
    always_comb begin
        w_Dec   = 28'(r_Level) * 28'(LP_STEP);
        w_Diff  = 24'd0;
        w_Speed = LP_MIN;
        if (w_Dec < 28'(LP_BASE)) begin
            w_Diff  = LP_BASE - w_Dec[23:0];
            w_Speed = (w_Diff < LP_MIN) ? LP_MIN : w_Diff;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Frame_Cnt   <= 8'd0;
            r_Lives       <= LP_LIVES;
            r_Level       <= 4'd0;
            r_Score       <= 8'd0;
            r_Car_Speed   <= LP_BASE;
            r_Game_Active <= 1'b0;
            r_Frog_Reset  <= 1'b0;
            r_Game_Over   <= 1'b0;
        end else begin
            r_Game_Active <= w_Game_Active;
            r_Frog_Reset  <= w_Frog_Reset;
            r_Game_Over   <= w_Game_Over;
            r_Car_Speed   <= w_Speed;
            if (w_Next_State != r_State)
                r_Frame_Cnt <= 8'd0;
            else if (w_Timed && i_Frame_Tick)
                r_Frame_Cnt <= r_Frame_Cnt + 8'd1;
            if (w_Load) begin
                r_Lives <= LP_LIVES;
                r_Level <= 4'd0;
                r_Score <= 8'd0;
            end else if (r_State == S_PLAY) begin
                if (i_Frog_Home) begin
                    if (r_Score != 8'hFF) r_Score <= r_Score + 8'd1;
                    if (r_Level < LP_MAXL) r_Level <= r_Level + 4'd1;
                end else if (i_Collision && r_Lives != 3'd0) begin
                    r_Lives <= r_Lives - 3'd1;
                end
            end
        end
    end

    assign o_Game_Active = r_Game_Active;
    assign o_Frog_Reset  = r_Frog_Reset;
    assign o_Game_Over   = r_Game_Over;
    assign o_Lives       = r_Lives;
    assign o_Level       = r_Level;
    assign o_Score       = r_Score;
    assign o_Car_Speed   = r_Car_Speed;
    assign o_State       = r_State;

endmodule

// File: tb/tb_frogg_round_ctrl.sv
// Scoreboard bench for frogg_round_ctrl: a phase/countdown reference model
// queues expected outputs per clock, a negedge monitor compares them.
module tb_frogg_round_ctrl;

    localparam int LIVES  = 3;
    localparam int MAXL   = 7;
    localparam int BASE   = 100000;
    localparam int STEP   = 10000;
    localparam int MINS   = 40000;
    localparam int NSPAWN = 2;
    localparam int NHIT   = 3;
    localparam int NWIN   = 3;

    localparam int P_IDLE  = 0;
    localparam int P_SPAWN = 1;
    localparam int P_PLAY  = 2;
    localparam int P_HIT   = 3;
    localparam int P_WIN   = 4;
    localparam int P_OVER  = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tick = 1'b0;
    logic        home = 1'b0;
    logic        coll = 1'b0;
    logic        ga;
    logic        fr;
    logic        go;
    logic [2:0]  lives;
    logic [3:0]  level;
    logic [7:0]  score;
    logic [23:0] speed;
    logic [2:0]  st;

    always #5 clk = ~clk;

    frogg_round_ctrl #(
        .c_LIVES(LIVES), .c_MAX_LEVEL(MAXL), .c_BASE_SPEED(BASE),
        .c_SPEED_STEP(STEP), .c_MIN_SPEED(MINS),
        .c_SPAWN_FRAMES(NSPAWN), .c_HIT_FRAMES(NHIT),
        .c_WIN_FRAMES(NWIN)
    ) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start),
        .i_Frame_Tick(tick), .i_Frog_Home(home), .i_Collision(coll),
        .o_Game_Active(ga), .o_Frog_Reset(fr), .o_Game_Over(go),
        .o_Lives(lives), .o_Level(level), .o_Score(score),
        .o_Car_Speed(speed), .o_State(st)
    );

    typedef struct {
        int st;
        int lives;
        int level;
        int score;
        int speed;
        bit ga;
        bit fr;
        bit go;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;

    // Reference model: phase plus frames remaining in that phase.
    int m_ph, m_lives, m_level, m_score, m_speed, m_rem;
    bit m_fr;

    function automatic int speed_of(int lvl);
        int s = BASE - lvl * STEP;
        return (s < MINS) ? MINS : s;
    endfunction

    function automatic int frames_of(int ph);
        if (ph == P_SPAWN) return NSPAWN;
        if (ph == P_HIT) return NHIT;
        if (ph == P_WIN) return NWIN;
        return 0;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_lives = LIVES; m_level = 0;
        m_score = 0; m_speed = BASE; m_rem = 0; m_fr = 0;
    endtask

    task automatic model_step(bit s, bit t, bit h, bit c);
        int nxt;
        bit done;
        int new_speed;
        new_speed = speed_of(m_level);
        nxt = m_ph;
        done = 0;
        if (m_ph == P_SPAWN || m_ph == P_HIT || m_ph == P_WIN) begin
            if (m_rem == 0) done = 1;
            else if (t) begin
                m_rem = m_rem - 1;
                done = (m_rem == 0);
            end
        end
        case (m_ph)
            P_IDLE, P_OVER: if (s) begin
                m_lives = LIVES; m_level = 0; m_score = 0;
                nxt = P_SPAWN;
            end
            P_SPAWN: if (done) nxt = P_PLAY;
            P_PLAY: begin
                if (h) begin
                    m_score = imin(m_score + 1, 255);
                    m_level = imin(m_level + 1, MAXL);
                    nxt = P_WIN;
                end else if (c) begin
                    m_lives = m_lives - 1;
                    nxt = P_HIT;
                end
            end
            P_HIT: if (done) nxt = (m_lives == 0) ? P_OVER : P_SPAWN;
            P_WIN: if (done) nxt = P_SPAWN;
            default: nxt = P_IDLE;
        endcase
        m_fr = (nxt == P_SPAWN) && (m_ph != P_SPAWN);
        if (nxt != m_ph) m_rem = frames_of(nxt);
        m_ph = nxt;
        m_speed = new_speed;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.st = m_ph; e.lives = m_lives; e.level = m_level;
        e.score = m_score; e.speed = m_speed;
        e.ga = (m_ph == P_PLAY); e.fr = m_fr; e.go = (m_ph == P_OVER);
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_all(exp_t e);
        chk("state", 32'(st), e.st);
        chk("lives", 32'(lives), e.lives);
        chk("level", 32'(level), e.level);
        chk("score", 32'(score), e.score);
        chk("speed", 32'(speed), e.speed);
        chk("active", 32'(ga), 32'(e.ga));
        chk("frog_reset", 32'(fr), 32'(e.fr));
        chk("game_over", 32'(go), 32'(e.go));
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check_all(mon_e);
        end
    end

    task automatic cyc(bit s, bit t, bit h, bit c);
        start = s; tick = t; home = h; coll = c;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(s, t, h, c);
        q.push_back(model_out());
        #1;
    endtask

    task automatic run_to(int target, int limit);
        int n = 0;
        while (m_ph != target && n < limit) begin
            cyc(0, 1'($urandom_range(0, 1)), 0, 0);
            n++;
        end
        if (m_ph != target) begin
            total++; bad++;
            $display("FAIL timeout: phase %0d expected %0d", m_ph, target);
        end
    endtask

    task automatic win();
        run_to(P_PLAY, 60);
        cyc(0, 0, 1, 0);
    endtask

    initial begin
        model_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        rst_n = 1'b1;
        repeat (4) cyc(0, 1, 0, 0);

        // Start, spawn pulse, PLAY on 2nd tick
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("play_after_spawn", 32'(st), P_PLAY);

        // Win path
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("speed_lvl1", 32'(speed), 90000);
        run_to(P_PLAY, 60);

        // Simultaneous home + collision
        cyc(0, 0, 1, 1);
        chk("simul_lives", 32'(lives), 3);
        run_to(P_PLAY, 60);

        // Lives exhausted
        cyc(0, 0, 0, 1);
        run_to(P_PLAY, 60);
        cyc(0, 0, 0, 1);
        run_to(P_PLAY, 60);
        cyc(0, 0, 0, 1);
        run_to(P_OVER, 60);
        chk("game_over", 32'(go), 1);
        chk("over_score", 32'(score), 2);
        repeat (3) cyc(0, 1, 1, 1);
        cyc(1, 0, 0, 0);
        chk("restart_lives", 32'(lives), 3);
        chk("restart_score", 32'(score), 0);

        // Level/speed saturation, then score saturation
        repeat (9) win();
        cyc(0, 0, 0, 0);
        chk("sat_level", 32'(level), 7);
        chk("sat_speed", 32'(speed), 40000);
        chk("nine_score", 32'(score), 9);
        repeat (247) win();
        cyc(0, 0, 0, 0);
        chk("score_255", 32'(score), 255);

        // Async reset mid-HIT with two frames counted
        run_to(P_PLAY, 60);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(model_out());
        cyc(0, 1, 0, 0);
        rst_n = 1'b1;
        repeat (5) cyc(0, 1, 1, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 7) == 0));
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
